bayer_mosaic_writer: RTL and testbench

BAYER_MOSAIC_WRITER -- requirements
Module: bayer_mosaic_writer

---
 rtl/bayer_mosaic_writer_pkg.sv | 43 ++++
 rtl/bayer_raster_counter.sv | 59 +++++
 rtl/bayer_mosaic_writer.sv | 149 ++++++++++++++
 tb/tb_bayer_mosaic_writer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bayer_mosaic_writer_pkg.sv
// Shared CFA definitions for the Bayer mosaic writer: channel symbols, mosaic layouts,
// controller states and the parity-to-channel lookup.
package bayer_mosaic_writer_pkg;

   typedef enum logic [1:0] {
      SymNone  = 2'b00,
      SymGreen = 2'b01,
      SymRed   = 2'b10,
      SymBlue  = 2'b11
   } bayer_sym_e;

   typedef enum logic [1:0] {
      PatRggb = 2'b00,
      PatGrbg = 2'b01,
      PatGbrg = 2'b10,
      PatBggr = 2'b11
   } cfa_pattern_e;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StDrain = 2'b10
   } fsm_state_e;

   // Green always sits on one diagonal of the 2x2 tile; the other diagonal holds R and B.
   function automatic bayer_sym_e cfa_channel(input cfa_pattern_e pat,
                                              input logic         row_par,
                                              input logic         col_par);
      bayer_sym_e sym;
      logic       diag;
      diag = row_par ^ col_par;
      sym  = SymGreen;
      case (pat)
         PatRggb: sym = diag ? SymGreen : (row_par ? SymBlue : SymRed);
         PatGrbg: sym = diag ? (row_par ? SymBlue : SymRed) : SymGreen;
         PatGbrg: sym = diag ? (row_par ? SymRed : SymBlue) : SymGreen;
         PatBggr: sym = diag ? SymGreen : (row_par ? SymRed : SymBlue);
         default: sym = SymGreen;
      endcase
      return sym;
   endfunction

endpackage

// File: rtl/bayer_raster_counter.sv
// Raster-order row/column/address counter with wrap at colMax and a last-pixel flag.
module bayer_raster_counter #(
   parameter int unsigned addressBitWidth = 17,
   parameter int unsigned rowBitWidth     = 11,
   parameter int unsigned colBitWidth     = 11
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clear_i,
   input  logic                       enable_i,
   input  logic [rowBitWidth-1:0]     row_max_i,
   input  logic [colBitWidth-1:0]     col_max_i,
   output logic                       row_par_o,
   output logic                       col_par_o,
   output logic [addressBitWidth-1:0] addr_o,
   output logic                       last_o
);

   logic [rowBitWidth-1:0]     row_q, row_d;
   logic [colBitWidth-1:0]     col_q, col_d;
   logic [addressBitWidth-1:0] addr_q, addr_d;

   always_comb begin
      row_d  = row_q;
      col_d  = col_q;
      addr_d = addr_q;
      if (clear_i) begin
         row_d  = '0;
         col_d  = '0;
         addr_d = '0;
      end else if (enable_i) begin
         addr_d = addr_q + 1'b1;
         if (col_q == col_max_i) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         row_q  <= '0;
         col_q  <= '0;
         addr_q <= '0;
      end else begin
         row_q  <= row_d;
         col_q  <= col_d;
         addr_q <= addr_d;
      end
   end

   assign row_par_o = row_q[0];
   assign col_par_o = col_q[0];
   assign addr_o    = addr_q;
   assign last_o    = (row_q == row_max_i) && (col_q == col_max_i);

endmodule

// File: rtl/bayer_mosaic_writer.sv
// Converts a raster stream of RGB pixels into single-channel Bayer mosaic memory writes,
// one registered write per accepted pixel with memReady backpressure.
module bayer_mosaic_writer
   import bayer_mosaic_writer_pkg::*;
#(
   parameter int unsigned addressBitWidth = 17,
   parameter int unsigned rowBitWidth     = 11,
   parameter int unsigned colBitWidth     = 11,
   parameter int unsigned dataBitWidth    = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [rowBitWidth-1:0]     rowMax,
   input  logic [colBitWidth-1:0]     colMax,
   input  logic [1:0]                 patternSelect,
   input  logic                       inValid,
   output logic                       inReady,
   input  logic [dataBitWidth-1:0]    greenIn,
   input  logic [dataBitWidth-1:0]    redIn,
   input  logic [dataBitWidth-1:0]    blueIn,
   input  logic                       memReady,
   output logic                       writeEnable,
   output logic [addressBitWidth-1:0] writeAddress,
   output logic [dataBitWidth-1:0]    rawWrite,
   output logic [1:0]                 bayerSymbol,
   output logic                       busy,
   output logic                       done
);

   fsm_state_e                 state_q, state_d;
   logic [rowBitWidth-1:0]     row_max_q;
   logic [colBitWidth-1:0]     col_max_q;
   cfa_pattern_e               pattern_q;
   logic                       we_q, we_d;
   logic [addressBitWidth-1:0] addr_q, addr_d;
   logic [dataBitWidth-1:0]    raw_q, raw_d;
   bayer_sym_e                 sym_q, sym_d;
   logic                       done_q, done_d;

   logic                       cfg_load, cnt_clear, accept, write_acc;
   logic                       row_par, col_par, cnt_last;
   logic [addressBitWidth-1:0] cnt_addr;
   bayer_sym_e                 pix_sym;
   logic [dataBitWidth-1:0]    pix_data;

   bayer_raster_counter #(
      .addressBitWidth (addressBitWidth),
      .rowBitWidth     (rowBitWidth),
      .colBitWidth     (colBitWidth)
   ) u_raster (
      .clk_i     (clk),
      .rst_ni    (rst),
      .clear_i   (cnt_clear),
      .enable_i  (accept),
      .row_max_i (row_max_q),
      .col_max_i (col_max_q),
      .row_par_o (row_par),
      .col_par_o (col_par),
      .addr_o    (cnt_addr),
      .last_o    (cnt_last)
   );

   // A new pixel may enter whenever the output slot is empty or draining this cycle.
   assign inReady   = (state_q == StRun) && (!we_q || memReady);
   assign accept    = inValid && inReady;
   assign write_acc = we_q && memReady;
   assign cfg_load  = (state_q == StIdle) && start;
   assign pix_sym   = cfa_channel(pattern_q, row_par, col_par);

   always_comb begin
      pix_data = greenIn;
      unique case (pix_sym)
         SymRed:  pix_data = redIn;
         SymBlue: pix_data = blueIn;
         default: pix_data = greenIn;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_clear = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRun;
               cnt_clear = 1'b1;
            end
         end
         StRun: begin
            if (accept && cnt_last) state_d = StDrain;
         end
         StDrain: begin
            if (write_acc) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      we_d   = we_q;
      addr_d = addr_q;
      raw_d  = raw_q;
      sym_d  = sym_q;
      done_d = (state_q == StDrain) && write_acc;
      if (accept) begin
         we_d   = 1'b1;
         addr_d = cnt_addr;
         raw_d  = pix_data;
         sym_d  = pix_sym;
      end else if (write_acc) begin
         we_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         row_max_q <= '0;
         col_max_q <= '0;
         pattern_q <= PatRggb;
         we_q      <= 1'b0;
         addr_q    <= '0;
         raw_q     <= '0;
         sym_q     <= SymNone;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (cfg_load) begin
            row_max_q <= rowMax;
            col_max_q <= colMax;
            pattern_q <= cfa_pattern_e'(patternSelect);
         end
         we_q   <= we_d;
         addr_q <= addr_d;
         raw_q  <= raw_d;
         sym_q  <= sym_d;
         done_q <= done_d;
      end
   end

   assign writeEnable  = we_q;
   assign writeAddress = addr_q;
   assign rawWrite     = raw_q;
   assign bayerSymbol  = sym_q;
   assign busy         = (state_q != StIdle);
   assign done         = done_q;

endmodule

// File: tb/tb_bayer_mosaic_writer.sv
// Randomised self-checking bench for bayer_mosaic_writer against a raster/pattern-string model.
module tb_bayer_mosaic_writer;

   localparam int AW = 17;
   localparam int RW = 11;
   localparam int CW = 11;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [RW-1:0] rowMax;
   logic [CW-1:0] colMax;
   logic [1:0]    patternSelect;
   logic          inValid;
   logic          inReady;
   logic [DW-1:0] greenIn, redIn, blueIn;
   logic          memReady;
   logic          writeEnable;
   logic [AW-1:0] writeAddress;
   logic [DW-1:0] rawWrite;
   logic [1:0]    bayerSymbol;
   logic          busy;
   logic          done;

   int errors = 0;
   int checks = 0;

   logic [AW-1:0] wr_addr[$];
   logic [DW-1:0] wr_raw[$];
   logic [1:0]    wr_sym[$];
   logic [DW-1:0] pg[$], pr[$], pb[$];
   int done_cnt, done_cyc, last_acc_cyc, hold_err, inrdy_err, busy_err;

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   bayer_mosaic_writer #(
      .addressBitWidth (AW),
      .rowBitWidth     (RW),
      .colBitWidth     (CW),
      .dataBitWidth    (DW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .rowMax        (rowMax),
      .colMax        (colMax),
      .patternSelect (patternSelect),
      .inValid       (inValid),
      .inReady       (inReady),
      .greenIn       (greenIn),
      .redIn         (redIn),
      .blueIn        (blueIn),
      .memReady      (memReady),
      .writeEnable   (writeEnable),
      .writeAddress  (writeAddress),
      .rawWrite      (rawWrite),
      .bayerSymbol   (bayerSymbol),
      .busy          (busy),
      .done          (done)
   );

   // Reference: pixel i lies at (i / width, i % width); tile parity picks a letter of the name.
   function automatic logic [1:0] model_sym(input logic [1:0] pat, input int i, input int cmax);
      string s;
      int    row, col, k;
      byte   ch;
      case (pat)
         2'd0:    s = "RGGB";
         2'd1:    s = "GRBG";
         2'd2:    s = "GBRG";
         default: s = "BGGR";
      endcase
      row = i / (cmax + 1);
      col = i % (cmax + 1);
      k   = 2 * (row % 2) + (col % 2);
      ch  = s[k];
      if (ch == "R") return 2'b10;
      else if (ch == "G") return 2'b01;
      else return 2'b11;
   endfunction

   function automatic logic [DW-1:0] model_data(input logic [1:0] sym, input int i);
      if (sym == 2'b10) return pr[i];
      else if (sym == 2'b01) return pg[i];
      else return pb[i];
   endfunction

   // Runs one frame, logging accepted writes and protocol violations observed each cycle.
   task automatic drive_frame(input logic [1:0] pat, input int rmax, input int cmax,
                              input int stall_pct, input int valid_pct, input int stall_a1,
                              input int mid_start_cyc, input bit fixed_px);
      int n, idx, cyc, a1_left;
      bit have_prev;
      logic [AW-1:0] p_addr;
      logic [DW-1:0] p_raw;
      logic [1:0]    p_sym;
      n = (rmax + 1) * (cmax + 1);
      wr_addr.delete(); wr_raw.delete(); wr_sym.delete();
      pg.delete(); pr.delete(); pb.delete();
      for (int i = 0; i < n; i++) begin
         pg.push_back(fixed_px ? DW'(1) : DW'($urandom));
         pr.push_back(fixed_px ? DW'(2) : DW'($urandom));
         pb.push_back(fixed_px ? DW'(3) : DW'($urandom));
      end
      done_cnt = 0; done_cyc = -1; last_acc_cyc = -1;
      hold_err = 0; inrdy_err = 0; busy_err = 0;
      have_prev = 1'b0; a1_left = stall_a1;
      p_addr = '0; p_raw = '0; p_sym = '0;
      @(negedge clk);
      start = 1'b1; rowMax = RW'(rmax); colMax = CW'(cmax); patternSelect = pat;
      inValid = 1'b0; memReady = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rowMax = RW'($urandom); colMax = CW'($urandom); patternSelect = 2'($urandom);
      idx = 0;
      for (cyc = 0; cyc < 4000; cyc++) begin
         memReady = ($urandom_range(99) >= stall_pct);
         if (a1_left > 0 && writeEnable && writeAddress == AW'(1)) begin
            memReady = 1'b0;
            a1_left--;
         end
         inValid = (idx < n) && ($urandom_range(99) < valid_pct);
         if (idx < n) begin
            greenIn = pg[idx]; redIn = pr[idx]; blueIn = pb[idx];
         end else begin
            greenIn = DW'($urandom); redIn = DW'($urandom); blueIn = DW'($urandom);
         end
         start = (cyc == mid_start_cyc);
         #1;
         if (have_prev && (!writeEnable || writeAddress !== p_addr || rawWrite !== p_raw ||
                           bayerSymbol !== p_sym)) hold_err++;
         have_prev = writeEnable && !memReady;
         p_addr = writeAddress; p_raw = rawWrite; p_sym = bayerSymbol;
         if (writeEnable && !memReady && inReady) inrdy_err++;
         if (idx == n && inReady) inrdy_err++;
         if (done_cnt == 0 && !done && !busy) busy_err++;
         if ((done_cnt > 0 || done) && busy) busy_err++;
         if (writeEnable && memReady) begin
            wr_addr.push_back(writeAddress);
            wr_raw.push_back(rawWrite);
            wr_sym.push_back(bayerSymbol);
            last_acc_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (inValid && inReady) idx++;
         if (done_cnt > 0 && cyc > done_cyc + 3) break;
         @(negedge clk);
      end
      start = 1'b0; inValid = 1'b0; memReady = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b1; inValid = 1'b1; memReady = 1'b1;
      rowMax = '0; colMax = '0; patternSelect = '0;
      greenIn = '0; redIn = '0; blueIn = '0;
      repeat (3) @(negedge clk);
      checks++; if (inReady !== 1'b0) begin
         errors++; $display("FAIL reset_inReady: got %b want 0", inReady);
      end
      checks++; if (writeEnable !== 1'b0) begin
         errors++; $display("FAIL reset_writeEnable: got %b want 0", writeEnable);
      end
      checks++; if (writeAddress !== '0) begin
         errors++; $display("FAIL reset_writeAddress: got %0d want 0", writeAddress);
      end
      checks++; if (rawWrite !== '0 || bayerSymbol !== 2'b00) begin
         errors++; $display("FAIL reset_data: got raw=%0h sym=%b want 0/00", rawWrite, bayerSymbol);
      end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_busy_done: got busy=%b done=%b want 0/0", busy, done);
      end
      start = 1'b0; inValid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_rggb_vector();
      logic [1:0]    es[4];
      logic [DW-1:0] er[4];
      es = '{2'b10, 2'b01, 2'b01, 2'b11};
      er = '{DW'(2), DW'(1), DW'(1), DW'(3)};
      drive_frame(2'b00, 1, 1, 0, 100, 0, -1, 1'b1);
      checks++; if (wr_addr.size() !== 4) begin
         errors++; $display("FAIL rggb_count: got %0d writes want 4", wr_addr.size());
      end
      for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
         checks++;
         if (wr_addr[i] !== AW'(i) || wr_raw[i] !== er[i] || wr_sym[i] !== es[i]) begin
            errors++;
            $display("FAIL rggb_write%0d: got addr=%0d raw=%0d sym=%b want addr=%0d raw=%0d sym=%b",
                     i, wr_addr[i], wr_raw[i], wr_sym[i], i, er[i], es[i]);
         end
      end
      checks++; if (done_cnt !== 1 || done_cyc !== last_acc_cyc + 1) begin
         errors++; $display("FAIL rggb_done: got count=%0d at cyc %0d want 1 at cyc %0d",
                            done_cnt, done_cyc, last_acc_cyc + 1);
      end
      checks++; if (busy_err !== 0 || inrdy_err !== 0) begin
         errors++; $display("FAIL rggb_busy_inReady: got busy_err=%0d inrdy_err=%0d want 0/0",
                            busy_err, inrdy_err);
      end
   endtask

   task automatic test_bggr_order();
      logic [1:0] es[4];
      es = '{2'b11, 2'b01, 2'b01, 2'b10};
      drive_frame(2'b11, 1, 1, 0, 100, 0, -1, 1'b0);
      checks++; if (wr_sym.size() !== 4) begin
         errors++; $display("FAIL bggr_count: got %0d writes want 4", wr_sym.size());
      end
      for (int i = 0; i < wr_sym.size() && i < 4; i++) begin
         checks++; if (wr_sym[i] !== es[i]) begin
            errors++; $display("FAIL bggr_sym%0d: got %b want %b", i, wr_sym[i], es[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [1:0]    es;
      logic [DW-1:0] ed;
      drive_frame(2'b00, 1, 1, 0, 100, 3, -1, 1'b0);
      checks++; if (hold_err !== 0 || inrdy_err !== 0) begin
         errors++; $display("FAIL stall_hold: got hold_err=%0d inrdy_err=%0d want 0/0",
                            hold_err, inrdy_err);
      end
      checks++; if (wr_addr.size() !== 4) begin
         errors++; $display("FAIL stall_count: got %0d writes want 4", wr_addr.size());
      end
      for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
         es = model_sym(2'b00, i, 1);
         ed = model_data(es, i);
         checks++;
         if (wr_addr[i] !== AW'(i) || wr_raw[i] !== ed || wr_sym[i] !== es) begin
            errors++;
            $display("FAIL stall_write%0d: got addr=%0d raw=%0h sym=%b want addr=%0d raw=%0h sym=%b",
                     i, wr_addr[i], wr_raw[i], wr_sym[i], i, ed, es);
         end
      end
   endtask

   task automatic test_single_pixel();
      drive_frame(2'b01, 0, 0, 0, 100, 0, -1, 1'b0);
      checks++; if (wr_addr.size() !== 1 || wr_addr[0] !== '0) begin
         errors++; $display("FAIL single_write: got %0d writes first addr=%0d want 1 at 0",
                            wr_addr.size(), (wr_addr.size() > 0) ? int'(wr_addr[0]) : -1);
      end
      checks++; if (wr_raw.size() > 0 && (wr_sym[0] !== 2'b01 || wr_raw[0] !== pg[0])) begin
         errors++; $display("FAIL single_data: got raw=%0h sym=%b want %0h/01",
                            wr_raw[0], wr_sym[0], pg[0]);
      end
      checks++; if (done_cnt !== 1 || done_cyc !== last_acc_cyc + 1 || busy_err !== 0) begin
         errors++; $display("FAIL single_done: got count=%0d cyc=%0d busy_err=%0d want 1 %0d 0",
                            done_cnt, done_cyc, busy_err, last_acc_cyc + 1);
      end
   endtask

   task automatic test_reset_midframe();
      @(negedge clk);
      start = 1'b1; rowMax = RW'(3); colMax = CW'(3); patternSelect = 2'b00;
      memReady = 1'b1;
      @(negedge clk);
      start = 1'b0; inValid = 1'b1;
      greenIn = DW'($urandom); redIn = DW'($urandom); blueIn = DW'($urandom);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({inReady, writeEnable, writeAddress, rawWrite, bayerSymbol, busy, done} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got rdy=%b we=%b addr=%0d raw=%0h sym=%b busy=%b done=%b want all 0",
                  inReady, writeEnable, writeAddress, rawWrite, bayerSymbol, busy, done);
      end
      rst = 1'b1; inValid = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || writeEnable !== 1'b0) begin
         errors++; $display("FAIL midreset_idle: got busy=%b we=%b want 0/0", busy, writeEnable);
      end
      drive_frame(2'b10, 3, 3, 0, 100, 0, -1, 1'b0);
      checks++; if (wr_addr.size() !== 16 || wr_addr[0] !== '0) begin
         errors++; $display("FAIL midreset_restart: got %0d writes first addr=%0d want 16 from 0",
                            wr_addr.size(), (wr_addr.size() > 0) ? int'(wr_addr[0]) : -1);
      end
   endtask

   task automatic test_start_ignored();
      logic [1:0]    es;
      logic [DW-1:0] ed;
      drive_frame(2'b00, 3, 3, 0, 100, 0, 5, 1'b0);
      checks++; if (wr_addr.size() !== 16 || done_cnt !== 1) begin
         errors++; $display("FAIL midstart_count: got %0d writes done=%0d want 16/1",
                            wr_addr.size(), done_cnt);
      end
      for (int i = 0; i < wr_addr.size() && i < 16; i++) begin
         es = model_sym(2'b00, i, 3);
         ed = model_data(es, i);
         checks++;
         if (wr_addr[i] !== AW'(i) || wr_raw[i] !== ed || wr_sym[i] !== es) begin
            errors++;
            $display("FAIL midstart_write%0d: got addr=%0d raw=%0h sym=%b want addr=%0d raw=%0h sym=%b",
                     i, wr_addr[i], wr_raw[i], wr_sym[i], i, ed, es);
         end
      end
   endtask

   task automatic test_random_frames();
      logic [1:0]    pat, es;
      logic [DW-1:0] ed;
      int            rmax, cmax, n;
      for (int t = 0; t < 8; t++) begin
         pat  = 2'($urandom);
         rmax = $urandom_range(4);
         cmax = $urandom_range(5);
         n    = (rmax + 1) * (cmax + 1);
         drive_frame(pat, rmax, cmax, 30, 70, 0, -1, 1'b0);
         checks++;
         if (wr_addr.size() !== n || done_cnt !== 1 || done_cyc !== last_acc_cyc + 1) begin
            errors++;
            $display("FAIL rand%0d_frame: got writes=%0d done=%0d@%0d want %0d 1@%0d",
                     t, wr_addr.size(), done_cnt, done_cyc, n, last_acc_cyc + 1);
         end
         checks++;
         if (hold_err !== 0 || inrdy_err !== 0 || busy_err !== 0) begin
            errors++;
            $display("FAIL rand%0d_protocol: got hold=%0d rdy=%0d busy=%0d want 0 0 0",
                     t, hold_err, inrdy_err, busy_err);
         end
         for (int i = 0; i < wr_addr.size() && i < n; i++) begin
            es = model_sym(pat, i, cmax);
            ed = model_data(es, i);
            checks++;
            if (wr_addr[i] !== AW'(i) || wr_raw[i] !== ed || wr_sym[i] !== es) begin
               errors++;
               $display("FAIL rand%0d_write%0d: got addr=%0d raw=%0h sym=%b want addr=%0d raw=%0h sym=%b",
                        t, i, wr_addr[i], wr_raw[i], wr_sym[i], i, ed, es);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_rggb_vector();
      test_bggr_order();
      test_backpressure();
      test_single_pixel();
      test_reset_midframe();
      test_start_ignored();
      test_random_frames();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
